mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory/MMU port between the IF stage (instruction fetch) and the MEM stage (load/store).
//  It owns the page-fault return path: the bus fault flag is routed only to the requester that owns the transfer.
//  It drops IF responses that a pipeline flush has killed.
//  Only one transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W          64  address width, both requesters and the bus
//  DATA_W          64  bus data width; the IF instruction is rdata[31:0]
//  MAX_MEM_STREAK  4   consecutive MEM grants allowed while IF waits (>=1)
// PORTS
//  clk            in   1       sole clock
//  rst            in   1       asynchronous, active-low reset
//  if_request     in   1       IF fetch request; held until if_gnt
//  if_addr        in   ADDR_W  fetch PC
//  if_flush       in   1       IF stage flushed this cycle
//  if_gnt         out  1       IF request accepted (1-cycle pulse)
//  if_rvalid      out  1       fetch response valid (1-cycle pulse)
//  if_inst        out  32      fetched instruction
//  if_page_fault  out  1       fetch page fault, qualified by if_rvalid
//  dm_request     in   1       MEM request; held until dm_gnt
//  dm_we          in   1       1 = store
//  dm_addr        in   ADDR_W  data address
//  dm_wdata       in   DATA_W  store data
//  dm_wmask       in   DATA_W/8  byte write mask
//  dm_gnt         out  1       MEM request accepted (1-cycle pulse)
//  dm_rvalid      out  1       MEM response valid (1-cycle pulse)
//  dm_rdata       out  DATA_W  load data
//  dm_page_fault  out  1       data page fault, qualified by dm_rvalid
//  bus_req        out  1       address phase valid
//  bus_we / bus_addr / bus_wdata / bus_wmask  out  registered copy of the granted request
//  bus_gnt        in   1       bus accepts the address phase
//  bus_rvalid     in   1       response valid (earliest: cycle after bus_gnt)
//  bus_rdata      in   DATA_W  response data
//  bus_fault      in   1       page fault, qualified by bus_rvalid
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, owner=IF, streak=0.
//   - All outputs 0; bus_* registers 0.
//  FSM states: IDLE -> ADDR -> DATA -> IDLE; side state DROP.
//  IDLE arbitration:
//   - Choose MEM if dm_request && !(if_request && !if_flush && streak==MAX_MEM_STREAK).
//   - Else choose IF if if_request && !if_flush.
//   - On a grant: pulse the matching *_gnt combinationally in the same cycle, latch the request into bus_* regs, set owner, go to ADDR.
//   - An IF grant always latches bus_we=0 and bus_wmask=0.
//  Streak counter:
//   - MEM grant with if_request high: streak+1, saturating at MAX.
//   - MEM grant with if_request low: streak=0.
//   - IF grant: streak=0.
//  ADDR:
//   - bus_req=1 until bus_gnt; on bus_gnt go to DATA.
//   - If owner=IF and if_flush=1 before bus_gnt: deassert bus_req next cycle and go to IDLE (withdraw allowed).
//   - if_flush and bus_gnt in the same cycle: DROP.
//  DATA: wait for bus_rvalid; responses pass through combinationally (0 added latency).
//   - Owner IF: if_rvalid=bus_rvalid, if_inst=bus_rdata[31:0], if_page_fault=bus_fault.
//   - Owner MEM: dm_rvalid, dm_rdata, dm_page_fault likewise.
//   - Non-owner response outputs stay 0.
//   - On bus_rvalid go to IDLE. A new grant is possible in the next cycle, not the same cycle.
//   - if_flush with owner IF and no bus_rvalid: DROP.
//   - if_flush with bus_rvalid in the same cycle: response suppressed (flush wins), go to IDLE.
//  DROP:
//   - Swallow bus_rvalid (no if_rvalid, fault discarded), then go to IDLE.
//   - if_request is not arbitrated until IDLE.
//  MEM transactions are never flushed. dm_flush does not exist; exceptions on MEM are handled downstream.
//  if_page_fault and dm_page_fault are never 1 without their rvalid.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined:
//   - Adds outputs perf_if_wait (32b) and perf_dm_wait (32b).
//   - Each counts cycles its requester is high and ungranted.
//   - Counters wrap at 2^32 and reset to 0.
//  ARB_PERF_CNT_EN undefined: no counters, no ports, no logic.
// TESTING
//  1 Only if_request, addr 0x8000_0000; bus_gnt at T+1, rvalid at T+3 with 0x00000013 -> if_gnt@T, if_rvalid@T+3, if_inst=0x13, dm_* 0.
//  2 if_request and dm_request held continuously, MAX=4, bus single-cycle -> grant order M,M,M,M,I,M,M,M,M,I.
//  3 IF granted, bus_gnt, if_flush in DATA, rvalid 2 cycles later -> if_rvalid stays 0; next IDLE grants the new request.
//  4 MEM load with bus_fault=1 at rvalid -> dm_rvalid=1, dm_page_fault=1, if_page_fault=0.
//  5 IF in ADDR, if_flush before bus_gnt -> bus_req falls next cycle, state IDLE, no response expected.
//  6 rst low during DATA -> all outputs 0 immediately; after release, IDLE grants dm_request first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory/MMU port between the IF stage (fetch) and the MEM
//   stage (load/store). One transaction is outstanding at a time. The bus
//   fault flag is returned only to the requester that owns the transfer.
//   IF responses killed by a pipeline flush are dropped.
//
// Ports
//   clk, rst (async, active-low)
//   IF  : if_request/if_addr/if_flush in; if_gnt/if_rvalid/if_inst/if_page_fault out
//   MEM : dm_request/dm_we/dm_addr/dm_wdata/dm_wmask in;
//         dm_gnt/dm_rvalid/dm_rdata/dm_page_fault out
//   Bus : bus_req/bus_we/bus_addr/bus_wdata/bus_wmask out;
//         bus_gnt/bus_rvalid/bus_rdata/bus_fault in
//
// Build option
//   ARB_PERF_CNT_EN : adds perf_if_wait / perf_dm_wait (32-bit wrap-around
//                     counts of cycles each requester waits ungranted).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_request,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_inst,
  output logic                  if_page_fault,
  input  logic                  dm_request,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_wmask,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_page_fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wmask,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_fault
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_if_wait,
  output logic [31:0]           perf_dm_wait
`endif
);

  localparam int unsigned SW = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DROP} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic [DATA_W/8-1:0]   bus_wmask_q, bus_wmask_d;

  logic if_ok;
  logic mem_pick;
  logic if_pick;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    streak_d      = streak_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_wmask_d   = bus_wmask_q;
    if_pick       = 1'b0;
    mem_pick      = 1'b0;
    bus_req       = 1'b0;
    if_rvalid     = 1'b0;
    if_inst       = '0;
    if_page_fault = 1'b0;
    dm_rvalid     = 1'b0;
    dm_rdata      = '0;
    dm_page_fault = 1'b0;
    if_ok         = if_request && !if_flush;

    unique case (state_q)
      S_IDLE: begin
        // MEM wins unless IF is eligible and MEM has used up its streak.
        mem_pick = dm_request && !(if_ok && streak_q == STREAK_MAX);
        if_pick  = !mem_pick && if_ok;
        if (mem_pick) begin
          owner_d     = OWN_MEM;
          state_d     = S_ADDR;
          bus_we_d    = dm_we;
          bus_addr_d  = dm_addr;
          bus_wdata_d = dm_wdata;
          bus_wmask_d = dm_wmask;
          if (!if_request)                streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
        end else if (if_pick) begin
          owner_d     = OWN_IF;
          state_d     = S_ADDR;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_wmask_d = '0;
          streak_d    = '0;
        end
      end
      S_ADDR: begin
        bus_req = 1'b1;
        // A flushed fetch may withdraw before acceptance; once the bus has
        // taken the address the response must still be swallowed.
        if (owner_q == OWN_IF && if_flush) state_d = bus_gnt ? S_DROP : S_IDLE;
        else if (bus_gnt)                  state_d = S_DATA;
      end
      S_DATA: begin
        if (owner_q == OWN_MEM) begin
          dm_rvalid     = bus_rvalid;
          dm_rdata      = bus_rvalid ? bus_rdata : '0;
          dm_page_fault = bus_rvalid && bus_fault;
          if (bus_rvalid) state_d = S_IDLE;
        end else if (bus_rvalid) begin
          state_d = S_IDLE;
          if (!if_flush) begin
            if_rvalid     = 1'b1;
            if_inst       = bus_rdata[31:0];
            if_page_fault = bus_fault;
          end
        end else if (if_flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (bus_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grants are combinational; masking with rst keeps them low while in reset.
  assign if_gnt    = if_pick && rst;
  assign dm_gnt    = mem_pick && rst;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wmask = bus_wmask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait_q, perf_if_wait_d;
  logic [31:0] perf_dm_wait_q, perf_dm_wait_d;

  always_comb begin
    perf_if_wait_d = perf_if_wait_q + {31'b0, (if_request && !if_pick)};
    perf_dm_wait_d = perf_dm_wait_q + {31'b0, (dm_request && !mem_pick)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_wait_q <= '0;
      perf_dm_wait_q <= '0;
    end else begin
      perf_if_wait_q <= perf_if_wait_d;
      perf_dm_wait_q <= perf_dm_wait_d;
    end
  end

  assign perf_if_wait = perf_if_wait_q;
  assign perf_dm_wait = perf_dm_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 64;
  localparam int unsigned DW   = 64;
  localparam int unsigned MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_request = 1'b0, if_flush = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid, if_page_fault;
  logic [31:0]   if_inst;
  logic          dm_request = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [7:0]    dm_wmask = '0;
  logic          dm_gnt, dm_rvalid, dm_page_fault;
  logic [DW-1:0] dm_rdata;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [7:0]    bus_wmask;
  logic          bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_fault = 1'b0;
  logic [DW-1:0] bus_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_MEM_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_request(if_request), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_inst(if_inst), .if_page_fault(if_page_fault),
    .dm_request(dm_request), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_page_fault(dm_page_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_fault(bus_fault)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Transaction-level model: one outstanding transfer described by flags.
  bit            m_busy, m_own_if, m_acc, m_killed, m_last_mem;
  int unsigned   m_streak;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_wmask;

  logic e_if_gnt, e_dm_gnt, e_bus_req;
  logic s_if_gnt, s_dm_gnt, s_bus_req, s_if_rvalid, s_dm_rvalid;
  logic s_if_pf, s_dm_pf, s_bus_we;
  logic [31:0]   s_if_inst;
  logic [DW-1:0] s_dm_rdata;
  logic [AW-1:0] s_bus_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own_if = 1; m_acc = 0; m_killed = 0; m_last_mem = 1;
    m_streak = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
  endtask

  // One clock cycle: entered at posedge+1 with inputs driven; compares
  // mid-cycle, advances the model, returns at the next posedge+1.
  task automatic step();
    bit if_ok, pick_mem, pick_if, resp, e_if_rv, e_dm_rv;
    #3;
    s_if_gnt = if_gnt; s_dm_gnt = dm_gnt; s_bus_req = bus_req;
    s_if_rvalid = if_rvalid; s_dm_rvalid = dm_rvalid; s_if_pf = if_page_fault;
    s_dm_pf = dm_page_fault; s_if_inst = if_inst; s_dm_rdata = dm_rdata;
    s_bus_addr = bus_addr; s_bus_we = bus_we;
    if (!rst) begin
      model_reset();
      pick_mem = 0; pick_if = 0; resp = 0; e_if_rv = 0; e_dm_rv = 0;
      e_bus_req = 0;
    end else begin
      if_ok    = if_request && !if_flush;
      pick_mem = !m_busy && dm_request && !(if_ok && m_streak == MAXS);
      pick_if  = !m_busy && !pick_mem && if_ok;
      e_bus_req = m_busy && !m_acc;
      resp     = m_busy && m_acc && !m_killed && bus_rvalid;
      e_if_rv  = resp && m_own_if && !if_flush;
      e_dm_rv  = resp && !m_own_if;
    end
    e_if_gnt = pick_if; e_dm_gnt = pick_mem;
    chk("if_gnt", if_gnt, 64'(pick_if));
    chk("dm_gnt", dm_gnt, 64'(pick_mem));
    chk("bus_req", bus_req, 64'(e_bus_req));
    chk("if_rvalid", if_rvalid, 64'(e_if_rv));
    chk("dm_rvalid", dm_rvalid, 64'(e_dm_rv));
    chk("if_page_fault", if_page_fault, 64'(e_if_rv && bus_fault));
    chk("dm_page_fault", dm_page_fault, 64'(e_dm_rv && bus_fault));
    chk("bus_we", bus_we, 64'(m_we));
    chk("bus_addr", bus_addr, m_addr);
    chk("bus_wmask", bus_wmask, 64'(m_wmask));
    if (m_last_mem) chk("bus_wdata", bus_wdata, m_wdata);
    if (e_if_rv) chk("if_inst", if_inst, 64'(bus_rdata[31:0]));
    if (e_dm_rv) chk("dm_rdata", dm_rdata, bus_rdata);
    if (rst) begin
      if (pick_mem) begin
        m_busy = 1; m_own_if = 0; m_acc = 0; m_killed = 0; m_last_mem = 1;
        m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_wmask = dm_wmask;
        m_streak = if_request ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (pick_if) begin
        m_busy = 1; m_own_if = 1; m_acc = 0; m_killed = 0; m_last_mem = 0;
        m_we = 0; m_addr = if_addr; m_wmask = '0; m_streak = 0;
      end else if (m_busy && !m_acc) begin
        if (m_own_if && if_flush) begin
          if (bus_gnt) begin m_acc = 1; m_killed = 1; end
          else m_busy = 0;
        end else if (bus_gnt) m_acc = 1;
      end else if (m_busy) begin
        if (bus_rvalid) m_busy = 0;
        else if (m_own_if && if_flush) m_killed = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    if_request = 0; if_flush = 0; dm_request = 0; dm_we = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_fault = 0;
  endtask

  // Finish any outstanding transfer with a prompt bus.
  task automatic drain();
    if_request = 0; dm_request = 0; if_flush = 0; bus_fault = 0;
    for (int i = 0; i < 30 && m_busy; i++) begin
      bus_gnt = 1;
      bus_rvalid = m_busy && m_acc;
      step();
    end
    if (m_busy) chk("drain_timeout", 64'(m_busy), 64'd0);
    bus_gnt = 0; bus_rvalid = 0;
  endtask

  initial begin
    string order;
    model_reset();
    @(posedge clk); #1;
    step(); step();
    chk("rst_bus_req", s_bus_req, 0);
    chk("rst_bus_addr", s_bus_addr, 0);
    rst = 1;
    step();

    // 1: lone fetch, bus_gnt at T+1, response at T+3
    if_request = 1; if_addr = 64'h8000_0000; step();
    chk("t1_if_gnt", s_if_gnt, 1);
    if_request = 0; bus_gnt = 1; step();
    chk("t1_bus_req", s_bus_req, 1);
    chk("t1_bus_addr", s_bus_addr, 64'h8000_0000);
    bus_gnt = 0; step();
    chk("t1_no_early_rv", s_if_rvalid, 0);
    bus_rvalid = 1; bus_rdata = 64'h13; step();
    chk("t1_if_rvalid", s_if_rvalid, 1);
    chk("t1_if_inst", s_if_inst, 32'h13);
    chk("t1_dm_rvalid", s_dm_rvalid, 0);
    bus_rvalid = 0; step();

    // 2: both held continuously, single-cycle bus
    order = "";
    if_request = 1; if_addr = 64'h1000; dm_request = 1; dm_we = 0; dm_addr = 64'h2000;
    bus_gnt = 1;
    for (int c = 0; c < 60 && order.len() < 10; c++) begin
      bus_rvalid = m_busy && m_acc;
      bus_rdata = 64'(c);
      step();
      if (s_dm_gnt) order = {order, "M"};
      if (s_if_gnt) order = {order, "I"};
    end
    n_checks++;
    if (order != "MMMMIMMMMI") begin
      n_errors++;
      $display("FAIL t2_grant_order: got %s expected MMMMIMMMMI", order);
    end
    drain();

    // 3: flush in DATA, response two cycles later is dropped
    if_request = 1; if_addr = 64'h3000; step();
    chk("t3_if_gnt", s_if_gnt, 1);
    if_request = 0; bus_gnt = 1; step();
    bus_gnt = 0; if_flush = 1; if_request = 1; if_addr = 64'h4000; step();
    chk("t3_flush_rv", s_if_rvalid, 0);
    if_flush = 0; step();
    chk("t3_drop_no_gnt", s_if_gnt, 0);
    bus_rvalid = 1; bus_rdata = 64'hdead_beef; bus_fault = 1; step();
    chk("t3_swallowed", s_if_rvalid, 0);
    chk("t3_no_pf", s_if_pf, 0);
    bus_rvalid = 0; bus_fault = 0; step();
    chk("t3_regrant", s_if_gnt, 1);
    drain();

    // 4: MEM load with page fault
    dm_request = 1; dm_we = 0; dm_addr = 64'h5000; step();
    chk("t4_dm_gnt", s_dm_gnt, 1);
    dm_request = 0; bus_gnt = 1; step();
    bus_gnt = 0; bus_rvalid = 1; bus_fault = 1; bus_rdata = 64'h1122_3344_5566_7788; step();
    chk("t4_dm_rvalid", s_dm_rvalid, 1);
    chk("t4_dm_pf", s_dm_pf, 1);
    chk("t4_if_pf", s_if_pf, 0);
    chk("t4_dm_rdata", s_dm_rdata, 64'h1122_3344_5566_7788);
    bus_rvalid = 0; bus_fault = 0; step();

    // 5: withdraw a fetch before bus_gnt
    if_request = 1; if_addr = 64'h6000; step();
    chk("t5_if_gnt", s_if_gnt, 1);
    if_request = 0; if_flush = 1; step();
    chk("t5_req_still_up", s_bus_req, 1);
    if_flush = 0; step();
    chk("t5_req_dropped", s_bus_req, 0);
    step();
    chk("t5_idle", s_bus_req, 0);

    // 6: reset during DATA
    dm_request = 1; dm_we = 1; dm_addr = 64'h7000; dm_wdata = 64'habcd; dm_wmask = 8'h0f;
    step();
    dm_request = 0; bus_gnt = 1; step();
    bus_gnt = 0; dm_request = 1; if_request = 1; rst = 0; step();
    chk("t6_rst_dm_gnt", s_dm_gnt, 0);
    chk("t6_rst_bus_req", s_bus_req, 0);
    chk("t6_rst_bus_we", s_bus_we, 0);
    chk("t6_rst_dm_rv", s_dm_rvalid, 0);
    rst = 1; step();
    chk("t6_dm_first", s_dm_gnt, 1);
    chk("t6_if_wait", s_if_gnt, 0);
    drain();

    // Randomized traffic
    clear_inputs();
    for (int c = 0; c < 4000; c++) begin
      int unsigned dm_rate;
      dm_rate = (c < 2000) ? 2 : 1;
      if_flush = ($urandom_range(0, 9) == 0);
      if (if_flush || !if_request) begin
        if_request = $urandom_range(0, 1);
        if_addr = {$urandom, $urandom};
      end
      if (!dm_request && $urandom_range(0, dm_rate) != 0) begin
        dm_request = 1; dm_we = $urandom_range(0, 1);
        dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
        dm_wmask = 8'($urandom);
      end
      bus_gnt = (m_busy && !m_acc) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_rvalid = (m_busy && m_acc) ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus_fault = 1'($urandom_range(0, 1));
      bus_rdata = {$urandom, $urandom};
      step();
      if (e_if_gnt) if_request = 0;
      if (e_dm_gnt) dm_request = 0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
